// File: rtl/pipeline_pkg.sv
// Shared types and constants for the retirement end of the pipeline.
package pipeline_pkg;

    typedef logic [4:0]  regind_t;
    typedef logic [31:0] regval_t;

    typedef struct packed {
        logic carry;
        logic negative;
        logic overflow;
        logic zero;
    } flags_t;

    localparam regind_t FLAGS_INDEX = 5'd31;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/store_port.sv
// Single-beat store engine on a wait-request bus: latches address/data,
// holds the request until the bus accepts it or the timeout expires.
module store_port #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        launch,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        mem_waitrequest,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_error,
    output logic        busy,
    output logic        done
);
    import pipeline_pkg::*;

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(MEM_TIMEOUT - 1);

    wb_state_t     state_r;
    wb_state_t     state_s;
    logic [CW-1:0] count_r;

    assign busy = (state_r == MEM_WAIT);
    assign done = (state_r == MEM_WAIT) && !mem_waitrequest;

    // Next-state selection for the store FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch) state_s = MEM_WAIT;
                else        state_s = IDLE;
            end
            MEM_WAIT: begin
                if (!mem_waitrequest)           state_s = IDLE;
                else if (count_r == LAST_COUNT) state_s = IDLE;
                else                            state_s = MEM_WAIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, bus request, latches and timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            count_r       <= '0;
            mem_write     <= 1'b0;
            mem_address   <= 32'h0000_0000;
            mem_writedata <= 32'h0000_0000;
            mem_error     <= 1'b0;
        end else begin
            state_r   <= state_s;
            mem_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    count_r <= '0;
                    if (launch) begin
                        mem_write     <= 1'b1;
                        mem_address   <= address;
                        mem_writedata <= data;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        count_r   <= '0;
                    end else if (count_r == LAST_COUNT) begin
                        mem_write <= 1'b0;
                        mem_error <= 1'b1;
                        count_r   <= '0;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                default: begin
                    mem_write <= 1'b0;
                    count_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: commits results to the register file and Flags,
// launches stores through store_port and signals retirement.
module write_back #(
    parameter int                        REG_COUNT_LOG2 = 5,
    parameter int                        MEM_TIMEOUT    = 16,
    parameter logic [REG_COUNT_LOG2-1:0] FLAGS_INDEX    = 5'd31
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_hold,
    input  logic [31:0]               in_pc,
    input  logic [REG_COUNT_LOG2-1:0] in_target_register,
    input  logic [REG_COUNT_LOG2-1:0] in_address_register,
    input  logic                      in_is_writing_memory,
    input  logic [3:0]                in_flags,
    input  logic [31:0]               in_target_value,
    input  logic                      in_has_upper_value,
    input  logic [31:0]               in_upper_value,
    input  logic [31:0]               in_adjustment_value,
    input  logic                      in_has_flushed,
    output logic [REG_COUNT_LOG2-1:0] base_index,
    input  logic [31:0]               base_value,
    output logic                      reg_we,
    output logic [REG_COUNT_LOG2-1:0] reg_windex,
    output logic [31:0]               reg_wvalue,
    output logic                      reg_we_upper,
    output logic [REG_COUNT_LOG2-1:0] reg_windex_upper,
    output logic [31:0]               reg_wvalue_upper,
    output logic                      flags_we,
    output logic [3:0]                flags_value,
    output logic                      mem_write,
    output logic [31:0]               mem_address,
    output logic [31:0]               mem_writedata,
    input  logic                      mem_waitrequest,
    output logic                      mem_error,
    output logic                      retire_valid,
    output logic [31:0]               retire_pc
);
    import pipeline_pkg::*;

    logic   busy_s, store_done_s;
    logic   accept_s, live_s, launch_s, reg_commit_s, flags_commit_s;
    flags_t flags_r;
    logic [31:0] store_pc_r;

    assign accept_s     = in_valid && !busy_s && !reset;
    assign live_s       = accept_s && !in_has_flushed;
    assign launch_s     = live_s && in_is_writing_memory;
    assign reg_commit_s = live_s && !in_is_writing_memory;
    // A low-port write of the Flags register carries the whole value, so it overrides the flag update.
    assign flags_commit_s = live_s && !(reg_commit_s && (in_target_register == FLAGS_INDEX));

    assign in_hold     = busy_s || launch_s;
    assign base_index  = in_address_register;
    assign flags_value = flags_r;

    store_port #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_store_port (
        .clock          (clock),
        .reset          (reset),
        .launch         (launch_s),
        .address        (base_value + in_adjustment_value),
        .data           (in_target_value),
        .mem_waitrequest(mem_waitrequest),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_error      (mem_error),
        .busy           (busy_s),
        .done           (store_done_s)
    );

    // Register-port, Flags and retire commit registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_we           <= 1'b0;
            reg_windex       <= '0;
            reg_wvalue       <= 32'h0000_0000;
            reg_we_upper     <= 1'b0;
            reg_windex_upper <= '0;
            reg_wvalue_upper <= 32'h0000_0000;
            flags_we         <= 1'b0;
            flags_r          <= 4'b0000;
            retire_valid     <= 1'b0;
            retire_pc        <= 32'h0000_0000;
            store_pc_r       <= 32'h0000_0000;
        end else begin
            reg_we       <= reg_commit_s;
            reg_we_upper <= reg_commit_s && in_has_upper_value;
            flags_we     <= flags_commit_s;
            retire_valid <= reg_commit_s || store_done_s;
            if (reg_commit_s) begin
                reg_windex <= in_target_register;
                reg_wvalue <= in_target_value;
                retire_pc  <= in_pc;
            end else if (store_done_s) begin
                retire_pc  <= store_pc_r;
            end
            if (reg_commit_s && in_has_upper_value) begin
                reg_windex_upper <= in_target_register + REG_COUNT_LOG2'(1);
                reg_wvalue_upper <= in_upper_value;
            end
            if (flags_commit_s) flags_r <= in_flags;
            if (launch_s) store_pc_r <= in_pc;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: table-driven register-path vectors plus
// hand-written store, timeout and reset sequences, checked through a scoreboard.
module tb_write_back;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_hold;
    logic [31:0] in_pc;
    logic [4:0]  in_target_register, in_address_register;
    logic        in_is_writing_memory;
    logic [3:0]  in_flags;
    logic [31:0] in_target_value;
    logic        in_has_upper_value;
    logic [31:0] in_upper_value, in_adjustment_value;
    logic        in_has_flushed;
    logic [4:0]  base_index;
    logic [31:0] base_value;
    logic        reg_we;
    logic [4:0]  reg_windex;
    logic [31:0] reg_wvalue;
    logic        reg_we_upper;
    logic [4:0]  reg_windex_upper;
    logic [31:0] reg_wvalue_upper;
    logic        flags_we;
    logic [3:0]  flags_value;
    logic        mem_write;
    logic [31:0] mem_address, mem_writedata;
    logic        mem_waitrequest, mem_error;
    logic        retire_valid;
    logic [31:0] retire_pc;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    write_back dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_hold(in_hold),
        .in_pc(in_pc), .in_target_register(in_target_register),
        .in_address_register(in_address_register),
        .in_is_writing_memory(in_is_writing_memory), .in_flags(in_flags),
        .in_target_value(in_target_value), .in_has_upper_value(in_has_upper_value),
        .in_upper_value(in_upper_value), .in_adjustment_value(in_adjustment_value),
        .in_has_flushed(in_has_flushed), .base_index(base_index), .base_value(base_value),
        .reg_we(reg_we), .reg_windex(reg_windex), .reg_wvalue(reg_wvalue),
        .reg_we_upper(reg_we_upper), .reg_windex_upper(reg_windex_upper),
        .reg_wvalue_upper(reg_wvalue_upper), .flags_we(flags_we), .flags_value(flags_value),
        .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_error(mem_error),
        .retire_valid(retire_valid), .retire_pc(retire_pc)
    );

    typedef struct {
        logic [4:0]  tgt;
        logic [31:0] val;
        logic [3:0]  flg;
        logic        up;
        logic [31:0] upv;
        logic        fl;
        logic [31:0] pc;
        logic        e_we;
        logic [4:0]  e_idx;
        logic [31:0] e_val;
        logic        e_weu;
        logic [4:0]  e_idxu;
        logic [31:0] e_valu;
        logic        e_fwe;
        logic [3:0]  e_flg;
        logic        e_ret;
    } vec_t;

    vec_t        vecs[5];
    vec_t        sb[$];
    logic [31:0] pc_sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = 32'h0; in_target_register = 5'd0;
        in_address_register = 5'd0; in_is_writing_memory = 1'b0; in_flags = 4'b0;
        in_target_value = 32'h0; in_has_upper_value = 1'b0; in_upper_value = 32'h0;
        in_adjustment_value = 32'h0; in_has_flushed = 1'b0;
    endtask

    task automatic drive_store(input logic [31:0] pc, input logic [31:0] base,
                               input logic [31:0] adj, input logic [31:0] data,
                               input logic [3:0] flg);
        in_valid = 1'b1; in_is_writing_memory = 1'b1; in_has_flushed = 1'b0;
        in_pc = pc; in_address_register = 5'd7; base_value = base;
        in_adjustment_value = adj; in_target_value = data; in_flags = flg;
        in_target_register = 5'd2; in_has_upper_value = 1'b0;
    endtask

    initial begin
        vec_t e;
        logic [31:0] exp_pc;
        int n;

        vecs[0] = '{5'd3,  32'h0000_00A5, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h100,
                    1'b1, 5'd3, 32'h0000_00A5, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0001, 1'b1};
        vecs[1] = '{5'd31, 32'h0000_0001, 4'b1010, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h104,
                    1'b1, 5'd31, 32'h0000_0001, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b1};
        vecs[2] = '{5'd5,  32'h5555_5555, 4'b1111, 1'b1, 32'h1, 1'b1, 32'h108,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{5'd0,  32'h1234_5678, 4'b0100, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h10C,
                    1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd1, 32'hCAFE_F00D, 1'b1, 4'b0100, 1'b1};
        vecs[4] = '{5'd10, 32'h8000_0000, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h110,
                    1'b1, 5'd10, 32'h8000_0000, 1'b0, 5'd0, 32'h0, 1'b1, 4'b1111, 1'b1};

        idle_inputs();
        base_value = 32'h0; mem_waitrequest = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_hold", in_hold, 0);   chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_we_upper", reg_we_upper, 0); chk("rst_flags_we", flags_we, 0);
        chk("rst_mem_write", mem_write, 0); chk("rst_mem_error", mem_error, 0);
        chk("rst_retire", retire_valid, 0); chk("rst_mem_address", mem_address, 0);
        chk("rst_reg_wvalue", reg_wvalue, 0); chk("rst_retire_pc", retire_pc, 0);
        chk("rst_flags_value", flags_value, 0);
        reset = 1'b0;

        // Back-to-back register-path vectors, including a flushed bubble.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_is_writing_memory = 1'b0;
            in_target_register = vecs[i].tgt; in_target_value = vecs[i].val;
            in_flags = vecs[i].flg; in_has_upper_value = vecs[i].up;
            in_upper_value = vecs[i].upv; in_has_flushed = vecs[i].fl; in_pc = vecs[i].pc;
            sb.push_back(vecs[i]);
            #1;
            chk("alu_in_hold", in_hold, 0);
            @(posedge clock); #1;
            e = sb.pop_front();
            chk("reg_we", reg_we, e.e_we);
            if (e.e_we) begin
                chk("reg_windex", reg_windex, e.e_idx);
                chk("reg_wvalue", reg_wvalue, e.e_val);
            end
            chk("reg_we_upper", reg_we_upper, e.e_weu);
            if (e.e_weu) begin
                chk("reg_windex_upper", reg_windex_upper, e.e_idxu);
                chk("reg_wvalue_upper", reg_wvalue_upper, e.e_valu);
            end
            chk("flags_we", flags_we, e.e_fwe);
            if (e.e_fwe) chk("flags_value", flags_value, e.e_flg);
            chk("retire_valid", retire_valid, e.e_ret);
            if (e.e_ret) chk("retire_pc", retire_pc, e.pc);
            chk("alu_mem_write", mem_write, 0);
        end
        idle_inputs();
        @(posedge clock); #1;
        chk("idle_reg_we", reg_we, 0);

        // Store with three wait cycles.
        mem_waitrequest = 1'b1;
        drive_store(32'h200, 32'h0000_1000, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011);
        pc_sb.push_back(32'h200);
        #1;
        chk("st_base_index", base_index, 5'd7);
        chk("st_launch_hold", in_hold, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("st_flags_we", flags_we, 1); chk("st_flags_value", flags_value, 4'b0011);
        chk("st_reg_we", reg_we, 0); chk("st_retire_early", retire_valid, 0);
        chk("st_writedata", mem_writedata, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            mem_waitrequest = (k < 3);
            #1;
            chk("st_mem_write", mem_write, 1);
            chk("st_mem_address", mem_address, 32'h0000_1010);
            chk("st_hold", in_hold, 1);
            chk("st_wait_retire", retire_valid, 0);
            @(posedge clock); #1;
        end
        mem_waitrequest = 1'b0;
        chk("st_done_mem_write", mem_write, 0);
        chk("st_retire", retire_valid, 1);
        exp_pc = pc_sb.pop_front();
        chk("st_retire_pc", retire_pc, exp_pc);
        chk("st_done_hold", in_hold, 0);
        chk("st_no_error", mem_error, 0);
        chk("st_no_reg_we", reg_we, 0);
        @(posedge clock); #1;
        chk("st_retire_pulse", retire_valid, 0);

        // Store timeout with waitrequest stuck high; address wraps downward.
        mem_waitrequest = 1'b1;
        drive_store(32'h300, 32'h0000_2000, 32'hFFFF_FFF0, 32'h0BAD_F00D, 4'b1000);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("to_mem_write_rise", mem_write, 1);
        chk("to_mem_address", mem_address, 32'h0000_1FF0);
        n = 0;
        while (!mem_error && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (retire_valid) chk("to_unexpected_retire", retire_valid, 0);
            if (!mem_error && !mem_write) chk("to_write_dropped_early", mem_write, 1);
        end
        chk("to_error_cycle", n, 16);
        chk("to_mem_write_drop", mem_write, 0);
        chk("to_no_retire", retire_valid, 0);
        chk("to_hold_released", in_hold, 0);
        @(posedge clock); #1;
        chk("to_error_pulse", mem_error, 0);

        // Reset in the middle of a store, then a clean store.
        drive_store(32'h400, 32'h0000_0100, 32'h0000_0004, 32'h1111_2222, 4'b0010);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("mr_in_wait", mem_write, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mr_mem_write", mem_write, 0); chk("mr_in_hold", in_hold, 0);
        chk("mr_mem_error", mem_error, 0); chk("mr_retire", retire_valid, 0);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        drive_store(32'h500, 32'h0000_0200, 32'h0000_0008, 32'h3333_4444, 4'b0001);
        pc_sb.push_back(32'h500);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("mr2_mem_write", mem_write, 1);
        chk("mr2_mem_address", mem_address, 32'h0000_0208);
        chk("mr2_writedata", mem_writedata, 32'h3333_4444);
        n = 0;
        while (!retire_valid && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        chk("mr2_retire_latency", n, 1);
        exp_pc = pc_sb.pop_front();
        chk("mr2_retire_pc", retire_pc, exp_pc);
        chk("mr2_mem_write_drop", mem_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
